// File: rtl/cpu_insencode_if.sv
// Purpose : request/response bus for the RISC-V instruction encoder.
//   master : producer of instruction fields, consumer of encoded words
//   slave  : the encoder itself
// Signals : in_valid/in_ready handshake with in_fmt, in_opcode, in_rd, in_rs1,
//           in_rs2, in_funct3, in_funct7, in_imm[XLEN-1:0];
//           out_valid/out_ready handshake with out_instr[31:0] and, when
//           ENCODE_RANGE_CHECK_EN is defined, out_err.
interface cpu_insencode_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_fmt;
  logic [6:0]      in_opcode;
  logic [4:0]      in_rd;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [2:0]      in_funct3;
  logic [6:0]      in_funct7;
  logic [XLEN-1:0] in_imm;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
`ifdef ENCODE_RANGE_CHECK_EN
  logic            out_err;
`endif

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr
`ifdef ENCODE_RANGE_CHECK_EN
    , input out_err
`endif
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr
`ifdef ENCODE_RANGE_CHECK_EN
    , output out_err
`endif
  );
endinterface

// File: rtl/cpu_insencode.sv
// Purpose : encodes RISC-V instruction fields into a 32-bit instruction word,
//           one registered stage behind a 2-entry skid buffer (output register
//           plus one skid entry), valid/ready on both sides.
// Ports   : clk      - clock, rising edge
//           reset_n  - synchronous reset, active-low
//           bus      - cpu_insencode_if.slave (request fields in, encoded word out)
// Options : ENCODE_RANGE_CHECK_EN - adds out_err, set when the immediate does
//           not fit the selected format (the word is still encoded by truncation).
module cpu_insencode #(
  parameter int unsigned XLEN = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  cpu_insencode_if.slave bus
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ISH = 3'd6;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic [XLEN-1:0] imm;
  logic [31:0]     enc_instr_c;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        in_ready_q, in_ready_d;
  logic        accept, drain;

  assign imm = bus.in_imm;

  // Field packing per instruction format
  always_comb begin
    enc_instr_c = NOP;
    case (bus.in_fmt)
      FMT_R:   enc_instr_c = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                              bus.in_rd, bus.in_opcode};
      FMT_I:   enc_instr_c = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      FMT_S:   enc_instr_c = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                              imm[4:0], bus.in_opcode};
      FMT_B:   enc_instr_c = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                              imm[4:1], imm[11], bus.in_opcode};
      FMT_U:   enc_instr_c = {imm[31:12], bus.in_rd, bus.in_opcode};
      FMT_J:   enc_instr_c = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
      FMT_ISH: begin
        // RV64 shamt is 6 bits and steals funct7[0]
        if (XLEN == 64)
          enc_instr_c = {bus.in_funct7[6:1], imm[5:0], bus.in_rs1, bus.in_funct3,
                         bus.in_rd, bus.in_opcode};
        else
          enc_instr_c = {bus.in_funct7, imm[4:0], bus.in_rs1, bus.in_funct3,
                         bus.in_rd, bus.in_opcode};
      end
      default: enc_instr_c = NOP;
    endcase
  end

`ifdef ENCODE_RANGE_CHECK_EN
  logic enc_err_c;
  logic out_err_q, out_err_d;
  logic skid_err_q, skid_err_d;
  logic fits12, fits13, fits21, fits32;

  // A value fits a signed N-bit field when all bits from N-1 upward agree
  always_comb begin
    fits12    = (&imm[XLEN-1:11]) | ~(|imm[XLEN-1:11]);
    fits13    = (&imm[XLEN-1:12]) | ~(|imm[XLEN-1:12]);
    fits21    = (&imm[XLEN-1:20]) | ~(|imm[XLEN-1:20]);
    fits32    = (&imm[XLEN-1:31]) | ~(|imm[XLEN-1:31]);
    enc_err_c = 1'b0;
    case (bus.in_fmt)
      FMT_I, FMT_S: enc_err_c = ~fits12;
      FMT_B:        enc_err_c = ~fits13 | imm[0];
      FMT_U:        enc_err_c = (|imm[11:0]) | ~fits32;
      FMT_J:        enc_err_c = ~fits21 | imm[0];
      FMT_ISH:      enc_err_c = (imm >= XLEN'(XLEN));
      FMT_R:        enc_err_c = 1'b0;
      default:      enc_err_c = 1'b1;
    endcase
  end
`endif

  // Output register + skid entry; in_ready tracks the skid entry being free
  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
`ifdef ENCODE_RANGE_CHECK_EN
    out_err_d    = out_err_q;
    skid_err_d   = skid_err_q;
`endif
    accept = bus.in_valid & in_ready_q;
    drain  = ~out_valid_q | bus.out_ready;

    if (skid_valid_q) begin
      // Output is full here, so out_ready means the head word leaves
      if (bus.out_ready) begin
        out_instr_d  = skid_instr_q;
        skid_valid_d = 1'b0;
`ifdef ENCODE_RANGE_CHECK_EN
        out_err_d    = skid_err_q;
`endif
      end
    end else if (accept) begin
      if (drain) begin
        out_valid_d = 1'b1;
        out_instr_d = enc_instr_c;
`ifdef ENCODE_RANGE_CHECK_EN
        out_err_d   = enc_err_c;
`endif
      end else begin
        skid_valid_d = 1'b1;
        skid_instr_d = enc_instr_c;
`ifdef ENCODE_RANGE_CHECK_EN
        skid_err_d   = enc_err_c;
`endif
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= 32'h0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 32'h0;
      in_ready_q   <= 1'b0;
`ifdef ENCODE_RANGE_CHECK_EN
      out_err_q    <= 1'b0;
      skid_err_q   <= 1'b0;
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      in_ready_q   <= in_ready_d;
`ifdef ENCODE_RANGE_CHECK_EN
      out_err_q    <= out_err_d;
      skid_err_q   <= skid_err_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
`ifdef ENCODE_RANGE_CHECK_EN
  assign bus.out_err   = out_err_q;
`endif

endmodule
